// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register-file addresses 0..Num_Regs-1 on a start pulse
// and streams each word to a debug sink over a valid/ready handshake.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   dump request, sampled only while idle
//   ReadAddress  out  register-file read address (AW bits)
//   Read_Data    in   combinational read data for ReadAddress
//   Dump_Data    out  word presented to the sink
//   Dump_Addr    out  index of Dump_Data (Num_Regs marks the checksum word)
//   Dump_Valid   out  Dump_Data/Dump_Addr/Dump_Last valid
//   Dump_Ready   in   sink accepts the current word
//   Dump_Last    out  final word of the dump
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse after the final handshake
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum word
// (Dump_Addr = Num_Regs) after the data words.

module reg_dump_reader #(
    parameter int Data_Width = 32,
    parameter int Num_Regs   = 32,
    localparam int AW        = $clog2(Num_Regs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [AW-1:0]         ReadAddress,
    input  logic [Data_Width-1:0] Read_Data,
    output logic [Data_Width-1:0] Dump_Data,
    output logic [AW:0]           Dump_Addr,
    output logic                  Dump_Valid,
    input  logic                  Dump_Ready,
    output logic                  Dump_Last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [AW:0] LastIdx = (AW+1)'(Num_Regs - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [AW:0] CsumIdx = (AW+1)'(Num_Regs);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        FIN
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [AW:0]           idx_q, idx_d;
    logic [Data_Width-1:0] data_q, data_d;
    logic [AW:0]           addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [Data_Width-1:0] acc_q, acc_d;
`endif

    logic hs;
    assign hs = valid_q & Dump_Ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                data_d  = Read_Data;
                addr_d  = idx_q;
                valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (idx_q == LastIdx);
`endif
                state_d = SEND;
            end

            SEND: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ data_q;
`endif
                    if (idx_q == LastIdx) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        done_d  = 1'b1;
                        state_d = FIN;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            // First cycle loads the checksum word; afterwards wait for the sink.
            CSUM: begin
                if (!valid_q) begin
                    data_d  = acc_q;
                    addr_d  = CsumIdx;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                end else if (Dump_Ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
`endif

            // Clearing idx here brings ReadAddress back to 0 for IDLE.
            FIN: begin
                idx_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign ReadAddress = idx_q[AW-1:0];
    assign Dump_Data   = data_q;
    assign Dump_Addr   = addr_q;
    assign Dump_Valid  = valid_q;
    assign Dump_Last   = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed bench for reg_dump_reader with a small
// register-file array driving Read_Data combinationally.

module tb_reg_dump_reader;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] ReadAddress;
    logic [DW-1:0] Read_Data;
    logic [DW-1:0] Dump_Data;
    logic [AW:0]   Dump_Addr;
    logic          Dump_Valid;
    logic          Dump_Ready = 1'b1;
    logic          Dump_Last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];

    int vec = 0;
    int miss = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign Read_Data = regs[ReadAddress];

    reg_dump_reader #(
        .Data_Width(DW),
        .Num_Regs  (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ReadAddress(ReadAddress),
        .Read_Data  (Read_Data),
        .Dump_Data  (Dump_Data),
        .Dump_Addr  (Dump_Addr),
        .Dump_Valid (Dump_Valid),
        .Dump_Ready (Dump_Ready),
        .Dump_Last  (Dump_Last),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) begin
        if (reset && Dump_Valid && Dump_Ready) hs_cnt++;
        if (reset && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_raddr"}, 64'(ReadAddress), 0);
        chk({tag, "_data"},  64'(Dump_Data),   0);
        chk({tag, "_addr"},  64'(Dump_Addr),   0);
        chk({tag, "_valid"}, 64'(Dump_Valid),  0);
        chk({tag, "_last"},  64'(Dump_Last),   0);
        chk({tag, "_busy"},  64'(busy),        0);
        chk({tag, "_done"},  64'(done),        0);
    endtask

    task automatic preload_seq();
        for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
    endtask

    task automatic run_dump(input string nm, input int stall_idx,
                            input int stall_n, input int again_idx,
                            input logic [DW-1:0] csum);
        int d0;
        int h0;
        logic [DW-1:0] hold_d;
        d0 = done_cnt;
        h0 = hs_cnt;
        @(negedge clk);
        start = 1'b1;
        Dump_Ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_fetch0_busy"},  64'(busy),       1);
        chk({nm, "_fetch0_valid"}, 64'(Dump_Valid), 0);
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            chk($sformatf("%s_w%0d_valid", nm, i), 64'(Dump_Valid), 1);
            chk($sformatf("%s_w%0d_addr", nm, i),  64'(Dump_Addr),  i);
            chk($sformatf("%s_w%0d_data", nm, i),  64'(Dump_Data),  regs[i]);
            chk($sformatf("%s_w%0d_last", nm, i),  64'(Dump_Last),
                64'((i == NR-1) && !CS));
            if (i == again_idx) start = 1'b1;
            if (i == stall_idx) begin
                hold_d = Dump_Data;
                Dump_Ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s_stall%0d_valid", nm, k),
                        64'(Dump_Valid), 1);
                    chk($sformatf("%s_stall%0d_addr", nm, k),
                        64'(Dump_Addr), i);
                    chk($sformatf("%s_stall%0d_data", nm, k),
                        64'(Dump_Data), 64'(hold_d));
                end
                Dump_Ready = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("%s_gap%0d_valid", nm, i), 64'(Dump_Valid), 0);
        end
        if (CS) begin
            chk({nm, "_csload_done"}, 64'(done), 0);
            @(negedge clk);
            chk({nm, "_cs_valid"}, 64'(Dump_Valid), 1);
            chk({nm, "_cs_addr"},  64'(Dump_Addr),  NR);
            chk({nm, "_cs_data"},  64'(Dump_Data),  64'(csum));
            chk({nm, "_cs_last"},  64'(Dump_Last),  1);
            @(negedge clk);
        end
        chk({nm, "_fin_done"}, 64'(done), 1);
        chk({nm, "_fin_busy"}, 64'(busy), 1);
        @(negedge clk);
        chk({nm, "_post_done"}, 64'(done), 0);
        chk({nm, "_post_busy"}, 64'(busy), 0);
        chk({nm, "_post_raddr"}, 64'(ReadAddress), 0);
        repeat (6) @(negedge clk);
        chk({nm, "_quiet_valid"}, 64'(Dump_Valid), 0);
        chk({nm, "_quiet_busy"},  64'(busy), 0);
        chk({nm, "_done_count"}, 64'(done_cnt - d0), 1);
        chk({nm, "_hs_count"},   64'(hs_cnt - h0), 64'(NR + int'(CS)));
    endtask

    initial begin
        bit found;
        preload_seq();
        #12;
        chk_idle_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle");

        // XOR of 0x1000_0000+i over 32 words: the constant cancels and
        // 0^1^...^31 is 0.
        run_dump("basic", -1, 0, -1, 32'h0000_0000);
        run_dump("bp", 7, 5, -1, 32'h0000_0000);
        run_dump("again", -1, 0, 10, 32'h0000_0000);

        for (int i = 0; i < NR; i++) regs[i] = '0;
        regs[3] = 32'hA5A5_A5A5;
        regs[9] = 32'h0F0F_0F0F;
        run_dump("csum", -1, 0, -1, 32'hAAAA_AAAA);

        preload_seq();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (Dump_Valid && Dump_Addr == 6'd15) found = 1'b1;
        end
        chk("mid_reach15", 64'(found), 1);
        Dump_Ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        chk_idle_outputs("midrst_hold");
        reset = 1'b1;
        Dump_Ready = 1'b1;
        @(negedge clk);
        run_dump("after_rst", -1, 0, -1, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
